// File: rtl/complex_mult_driver.sv
// Initiator for the complex multiplier: buffers host operand sets, issues one transaction
// at a time over op_val/op_ready, and queues the products for a downstream consumer.
module complex_mult_driver #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    sw_rst,
   input  logic                    in_val,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_op_1_re,
   input  logic [DATA_WIDTH-1:0]   in_op_1_im,
   input  logic [DATA_WIDTH-1:0]   in_op_2_re,
   input  logic [DATA_WIDTH-1:0]   in_op_2_im,
   output logic                    m_op_val,
   input  logic                    m_op_ready,
   output logic [DATA_WIDTH-1:0]   m_op_1_re,
   output logic [DATA_WIDTH-1:0]   m_op_1_im,
   output logic [DATA_WIDTH-1:0]   m_op_2_re,
   output logic [DATA_WIDTH-1:0]   m_op_2_im,
   input  logic                    m_res_val,
   output logic                    m_res_ready,
   input  logic [2*DATA_WIDTH-1:0] m_result_re,
   input  logic [2*DATA_WIDTH-1:0] m_result_im,
   output logic                    out_val,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_re,
   output logic [2*DATA_WIDTH-1:0] out_im,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    done_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 4 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

   state_t        state;
   logic [EW-1:0] op_mem  [FIFO_DEPTH];
   logic [EW-1:0] res_mem [FIFO_DEPTH];
   logic [AW-1:0] op_wr, op_rd, res_wr, res_rd;
   logic [AW:0]   op_cnt, res_cnt;
   logic          op_push, op_pop, res_push, res_pop;

   // Depth is a power of two and count never exceeds it, so the MSB alone flags full.
   assign in_ready    = !op_cnt[AW];
   assign op_push     = in_val && in_ready;
   assign op_pop      = (state == ISSUE) && m_op_ready;
   assign m_res_ready = (state == WAIT_RES) && !res_cnt[AW];
   assign res_push    = m_res_val && m_res_ready;
   assign out_val     = (res_cnt != '0);
   assign res_pop     = out_val && out_ready;
   assign out_re      = res_mem[res_rd][EW-1 -: 2*DATA_WIDTH];
   assign out_im      = res_mem[res_rd][2*DATA_WIDTH-1:0];
   assign busy        = (state != IDLE) || (op_cnt != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_wr  <= '0;
         op_rd  <= '0;
         op_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) op_mem[i] <= '0;
      end else if (sw_rst) begin
         op_wr  <= '0;
         op_rd  <= '0;
         op_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) op_mem[i] <= '0;
      end else begin
         if (op_push) begin
            op_mem[op_wr] <= {in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im};
            op_wr         <= op_wr + 1'b1;
         end
         if (op_pop) op_rd <= op_rd + 1'b1;
         case ({op_push, op_pop})
            2'b10:   op_cnt <= op_cnt + 1'b1;
            2'b01:   op_cnt <= op_cnt - 1'b1;
            default: op_cnt <= op_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_wr  <= '0;
         res_rd  <= '0;
         res_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) res_mem[i] <= '0;
      end else if (sw_rst) begin
         res_wr  <= '0;
         res_rd  <= '0;
         res_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) res_mem[i] <= '0;
      end else begin
         if (res_push) begin
            res_mem[res_wr] <= {m_result_re, m_result_im};
            res_wr          <= res_wr + 1'b1;
         end
         if (res_pop) res_rd <= res_rd + 1'b1;
         case ({res_push, res_pop})
            2'b10:   res_cnt <= res_cnt + 1'b1;
            2'b01:   res_cnt <= res_cnt - 1'b1;
            default: res_cnt <= res_cnt;
         endcase
      end
   end

   // Transaction sequencer: operands are latched on IDLE->ISSUE and held through the handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         m_op_val <= 1'b0;
         {m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im} <= '0;
         done_cnt <= '0;
      end else if (sw_rst) begin
         state    <= IDLE;
         m_op_val <= 1'b0;
         {m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im} <= '0;
         done_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_cnt != '0) begin
                  {m_op_1_re, m_op_1_im, m_op_2_re, m_op_2_im} <= op_mem[op_rd];
                  m_op_val <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_op_ready) begin
                  m_op_val <= 1'b0;
                  state    <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (res_push) begin
                  done_cnt <= done_cnt + 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               m_op_val <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
